// File: rtl/elevador_scheduler.sv
// SmartCargo car scheduler: latches floor requests, serves them in SCAN order,
// drives the motor and times the door. Optional movement timeout: MOVE_TIMEOUT_EN.
module elevador_scheduler #(
   parameter int DOOR_CYCLES    = 100,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] pedido,
   input  logic       medida_pronta,
   input  logic       no_andar,
   input  logic [1:0] andar_exato,
   output logic       motor_sobe,
   output logic       motor_desce,
   output logic       porta_aberta,
   output logic [3:0] pedidos_pendentes,
   output logic [1:0] andar_atual,
   output logic       direcao,
   output logic       falha,
   output logic [2:0] estado
);

   typedef enum logic [2:0] {
      PARADO   = 3'd0,
      SUBINDO  = 3'd1,
      DESCENDO = 3'd2,
      PORTA    = 3'd3,
      FALHA    = 3'd4
   } state_t;

   if (DOOR_CYCLES < 1 || DOOR_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("elevador_scheduler: parameter out of range");
   end

   state_t      state, state_nx;
   logic [15:0] door_tmr, door_tmr_nx;
   logic [3:0]  pend_nx;
   logic        dir_nx;
   logic        hit, above, below;

   assign hit = medida_pronta & no_andar;

   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (pedidos_pendentes[i] && (2'(i) > andar_atual)) above = 1'b1;
         if (pedidos_pendentes[i] && (2'(i) < andar_atual)) below = 1'b1;
      end
   end

`ifdef MOVE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] mv_cnt, mv_cnt_nx;
`endif

   always_comb begin
      state_nx    = state;
      dir_nx      = direcao;
      door_tmr_nx = door_tmr;
      pend_nx     = pedidos_pendentes | pedido;
      case (state)
         PARADO: begin
            if (pedidos_pendentes[andar_atual])  state_nx = PORTA;
            else if (direcao && above)           state_nx = SUBINDO;
            else if (!direcao && below)          state_nx = DESCENDO;
            else if (above) begin
               state_nx = SUBINDO;
               dir_nx   = 1'b1;
            end else if (below) begin
               state_nx = DESCENDO;
               dir_nx   = 1'b0;
            end
         end
         SUBINDO: begin
            if (hit) begin
               if (pedidos_pendentes[andar_exato]) state_nx = PORTA;
               else if (andar_exato == 2'd3)       state_nx = PARADO;
            end
         end
         DESCENDO: begin
            if (hit) begin
               if (pedidos_pendentes[andar_exato]) state_nx = PORTA;
               else if (andar_exato == 2'd0)       state_nx = PARADO;
            end
         end
         PORTA: begin
            // a press of the floor we are standing at holds the door instead of latching
            pend_nx[andar_atual] = 1'b0;
            if (pedido[andar_atual])                      door_tmr_nx = '0;
            else if (door_tmr == 16'(DOOR_CYCLES - 1))    state_nx    = PARADO;
            else                                          door_tmr_nx = door_tmr + 16'd1;
         end
`ifdef MOVE_TIMEOUT_EN
         FALHA: state_nx = FALHA;
`endif
         default: state_nx = PARADO;
      endcase
      if (state_nx == PORTA && state != PORTA) door_tmr_nx = '0;
`ifdef MOVE_TIMEOUT_EN
      mv_cnt_nx = '0;
      if ((state == SUBINDO || state == DESCENDO) && state_nx == state && !hit) begin
         if (mv_cnt == TW'(TIMEOUT_CYCLES - 1)) state_nx  = FALHA;
         else                                   mv_cnt_nx = mv_cnt + 1'b1;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= PARADO;
         door_tmr          <= '0;
         pedidos_pendentes <= '0;
         andar_atual       <= '0;
         direcao           <= 1'b1;
         motor_sobe        <= 1'b0;
         motor_desce       <= 1'b0;
         porta_aberta      <= 1'b0;
         estado            <= '0;
      end else begin
         state             <= state_nx;
         door_tmr          <= door_tmr_nx;
         pedidos_pendentes <= pend_nx;
         direcao           <= dir_nx;
         if (hit) andar_atual <= andar_exato;
         motor_sobe        <= (state_nx == SUBINDO);
         motor_desce       <= (state_nx == DESCENDO);
         porta_aberta      <= (state_nx == PORTA);
         estado            <= state_nx;
      end
   end

`ifdef MOVE_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mv_cnt <= '0;
         falha  <= 1'b0;
      end else begin
         mv_cnt <= mv_cnt_nx;
         falha  <= (state_nx == FALHA);
      end
   end
`else
   assign falha = 1'b0;
`endif

endmodule

// File: tb/tb_elevador_scheduler.sv
// Scoreboard bench for elevador_scheduler: expected door stops are queued as
// stimulus is driven and matched when the door closes.
module tb_elevador_scheduler;

   logic       clock, reset;
   logic [3:0] pedido;
   logic       medida_pronta, no_andar;
   logic [1:0] andar_exato;
   logic       motor_sobe, motor_desce, porta_aberta, direcao, falha;
   logic [3:0] pedidos_pendentes;
   logic [1:0] andar_atual;
   logic [2:0] estado;

   elevador_scheduler #(.DOOR_CYCLES(100), .TIMEOUT_CYCLES(2000)) dut (
      .clock(clock), .reset(reset), .pedido(pedido), .medida_pronta(medida_pronta),
      .no_andar(no_andar), .andar_exato(andar_exato), .motor_sobe(motor_sobe),
      .motor_desce(motor_desce), .porta_aberta(porta_aberta),
      .pedidos_pendentes(pedidos_pendentes), .andar_atual(andar_atual),
      .direcao(direcao), .falha(falha), .estado(estado)
   );

   typedef struct {
      int floor;
      int dur;
   } stop_t;

   stop_t sb[$];
   stop_t exp_stop;
   int    checks = 0;
   int    failures = 0;
   int    door_cnt = 0;
   int    door_floor = 0;
   logic  door_q = 1'b0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic [3:0] p);
      pedido = p;
      tick();
      pedido = '0;
   endtask

   task automatic hit(input logic [1:0] f);
      medida_pronta = 1'b1;
      no_andar      = 1'b1;
      andar_exato   = f;
      tick();
      medida_pronta = 1'b0;
      no_andar      = 1'b0;
   endtask

   task automatic push(input int f, input int d);
      stop_t s;
      s.floor = f;
      s.dur   = d;
      sb.push_back(s);
   endtask

   task automatic wait_state(input logic [2:0] st, input int lim);
      int n = 0;
      while (estado !== st && n < lim) begin
         tick();
         n++;
      end
      chk("wait_st", estado, st);
   endtask

   // door monitor: measures each opening and matches it against the queue
   always @(posedge clock) begin
      #1;
      chk("excl", {31'd0, (motor_sobe & motor_desce) | (porta_aberta & (motor_sobe | motor_desce))}, 0);
`ifndef MOVE_TIMEOUT_EN
      chk("falha_tie", falha, 0);
`endif
      if (reset) begin
         door_cnt = 0;
         door_q   = 1'b0;
      end else begin
         if (porta_aberta) begin
            if (!door_q) door_floor = andar_atual;
            door_cnt++;
         end else if (door_q) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
               exp_stop = sb.pop_front();
               chk("stop_floor", door_floor, exp_stop.floor);
               chk("door_len", door_cnt, exp_stop.dur);
            end
            door_cnt = 0;
         end
         door_q = porta_aberta;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; pedido = '0; medida_pronta = 1'b0; no_andar = 1'b0; andar_exato = '0;
      tick(); tick();
      chk("rst_estado", estado, 0);
      chk("rst_dir", direcao, 1);
      chk("rst_outs", {motor_sobe, motor_desce, porta_aberta, falha}, 0);
      chk("rst_pend", pedidos_pendentes, 0);
      chk("rst_andar", andar_atual, 0);
      reset = 1'b0;
      tick();

      // floor 0 -> request 2, pass floor 1
      push(2, 100);
      pulse(4'b0100);
      chk("A_pend", pedidos_pendentes, 4'b0100);
      chk("A_est0", estado, 0);
      tick();
      chk("A_up", {estado, motor_sobe}, {3'd1, 1'b1});
      hit(2'd1);
      chk("A_pass1", {estado, andar_atual}, {3'd1, 2'd1});
      hit(2'd2);
      chk("A_door", {estado, porta_aberta, motor_sobe}, {3'd3, 1'b1, 1'b0});
      repeat (50) tick();
      chk("A_pend_clr", pedidos_pendentes, 0);
      wait_state(3'd0, 200);

      // floor 2, up preference, pending {0,3}: serve 3 first
      push(3, 100);
      push(0, 100);
      pulse(4'b1001);
      tick();
      chk("B_up", estado, 1);
      hit(2'd3);
      chk("B_door3", estado, 3);
      wait_state(3'd0, 200);
      chk("B_pend", pedidos_pendentes, 4'b0001);
      tick();
      chk("B_down", {estado, direcao, motor_desce}, {3'd2, 1'b0, 1'b1});
      hit(2'd2);
      hit(2'd1);
      chk("B_pass", {estado, andar_atual}, {3'd2, 2'd1});
      hit(2'd0);
      chk("B_door0", estado, 3);
      wait_state(3'd0, 200);

      // floor 0, request 3, then floor 1 pressed while moving
      push(1, 100);
      push(3, 100);
      pulse(4'b1000);
      tick();
      chk("C_up", {estado, direcao}, {3'd1, 1'b1});
      pulse(4'b0010);
      chk("C_pend", pedidos_pendentes, 4'b1010);
      hit(2'd1);
      chk("C_door1", estado, 3);
      wait_state(3'd0, 200);
      chk("C_pend3", pedidos_pendentes, 4'b1000);
      tick();
      chk("C_resume", estado, 1);
      hit(2'd2);
      chk("C_pass2", estado, 1);
      hit(2'd3);
      chk("C_door3", estado, 3);
      wait_state(3'd0, 200);

      // back down to floor 1
      push(1, 100);
      pulse(4'b0010);
      tick();
      chk("M_down", {estado, direcao}, {3'd2, 1'b0});
      hit(2'd2);
      hit(2'd1);
      wait_state(3'd0, 200);

      // standing at 1: own-floor press opens door without motion; re-press at 50
      push(1, 150);
      pulse(4'b0010);
      chk("D_still", {estado, motor_sobe, motor_desce}, {3'd0, 1'b0, 1'b0});
      tick();
      chk("D_door", {estado, porta_aberta, motor_sobe, motor_desce}, {3'd3, 1'b1, 1'b0, 1'b0});
      repeat (49) tick();
      pedido = 4'b0010;
      tick();
      pedido = '0;
      chk("D_nolatch", pedidos_pendentes, 0);
      wait_state(3'd0, 300);

      // end-stop at 3 with nothing pending there; ignored non-floor measurement
      push(2, 100);
      pulse(4'b0100);
      tick();
      chk("E_up", {estado, direcao}, {3'd1, 1'b1});
      hit(2'd3);
      chk("E_endstop", {estado, motor_sobe, andar_atual}, {3'd0, 1'b0, 2'd3});
      tick();
      chk("E_down", {estado, direcao}, {3'd2, 1'b0});
      medida_pronta = 1'b1; no_andar = 1'b0; andar_exato = 2'd2;
      tick();
      medida_pronta = 1'b0;
      chk("E_ignore", {estado, andar_atual}, {3'd2, 2'd3});
      hit(2'd2);
      chk("E_door2", estado, 3);
      wait_state(3'd0, 200);

      // asynchronous reset in the middle of a climb
      pulse(4'b1000);
      tick();
      chk("F_up", motor_sobe, 1);
      #2 reset = 1'b1;
      #1;
      chk("F_rst_motor", {motor_sobe, motor_desce, porta_aberta}, 0);
      chk("F_rst_state", {estado, direcao}, {3'd0, 1'b1});
      chk("F_rst_regs", {pedidos_pendentes, andar_atual}, 0);
      tick();
      reset = 1'b0;
      tick();

`ifdef MOVE_TIMEOUT_EN
      pulse(4'b1000);
      tick();
      chk("T_up", estado, 1);
      repeat (2005) tick();
      chk("T_fault", {falha, estado, motor_sobe, motor_desce, porta_aberta}, {1'b1, 3'd4, 3'b000});
      pulse(4'b0001);
      chk("T_latch", pedidos_pendentes, 4'b1001);
      repeat (5) tick();
      chk("T_hold", estado, 4);
      reset = 1'b1;
      #1;
      chk("T_rst", {falha, estado}, 0);
      tick();
      reset = 1'b0;
      tick();
`endif

      chk("sb_left", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/elevador_scheduler.md
Name: elevador_scheduler

Overview:
- Sequences the SmartCargo car from floor-position data produced by the cm-to-floor converter.
- Latches hall/cab floor requests and serves them in collective (SCAN) order.
- Drives the up/down motor commands and times door-open dwell.
- Sits between the converter and the motor/door drivers; all outputs are registered (Moore).

Parameters:
- DOOR_CYCLES, 100, clock cycles the door stays open per stop (1..2^16-1).
- TIMEOUT_CYCLES, 2000, max cycles between valid floor readings while moving (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- pedido  input  4  request level per floor (bit i = floor i), sampled every clock
- medida_pronta  input  1  one-cycle strobe: new sensor measurement converted
- no_andar  input  1  1 = measured height lies inside a floor band (andar_exato meaningful)
- andar_exato  input  2  floor index from converter, valid when medida_pronta & no_andar
- motor_sobe  output  1  motor up command
- motor_desce  output  1  motor down command
- porta_aberta  output  1  door open command
- pedidos_pendentes  output  4  latched pending requests
- andar_atual  output  2  last confirmed floor
- direcao  output  1  1 = up preference, 0 = down
- falha  output  1  movement-timeout fault flag
- estado  output  3  state code for debug/display

Behaviour:
- Reset (async): state PARADO; all outputs 0, pedidos_pendentes=0, andar_atual=0, direcao=1, timers 0. Reset mid-move stops motors at once.
- "Floor hit" = medida_pronta & no_andar; on a floor hit, andar_atual <= andar_exato in any state.
- Request latch: pedidos_pendentes[i] <= pedidos_pendentes[i] | pedido[i] every cycle.
  - Exception: in PORTA, bit andar_atual is forced 0. A press of the current floor while in PORTA restarts the door timer and is not latched.
- "Above" = any pending bit > andar_atual; "below" = any pending bit < andar_atual.
- States (estado code): PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3, FALHA=4.
- PARADO (all outputs 0 except status):
  - pending[andar_atual] -> PORTA.
  - else direcao=1 & above -> SUBINDO.
  - else direcao=0 & below -> DESCENDO.
  - else above -> SUBINDO, direcao<=1.
  - else below -> DESCENDO, direcao<=0.
  - else stay.
- SUBINDO (motor_sobe=1):
  - floor hit with pending[andar_exato] -> PORTA.
  - floor hit with andar_exato=3 and nothing pending there -> PARADO (end-stop safety).
  - non-pending floors are passed.
- DESCENDO (motor_desce=1): mirror of SUBINDO; end-stop is floor 0.
- PORTA (porta_aberta=1):
  - timer counts 0..DOOR_CYCLES-1; at terminal count -> PARADO.
  - timer clears on entry and on restart.
- Latency: one clock from decision input to registered output change (e.g. floor hit at edge N -> motor 0 and porta_aberta 1 after edge N+1).
- Invariant: motor_sobe & motor_desce never both 1; porta_aberta never 1 with either motor.
- Simultaneous events:
  - new requests in the same cycle as a decision are seen next cycle.
  - requests above and below with no direction preference go up (direcao=1 default).
- medida_pronta with no_andar=0: ignored by FSM and andar_atual.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - counter runs in SUBINDO/DESCENDO and clears on every floor hit and on state entry.
  - reaching TIMEOUT_CYCLES -> FALHA: motors 0, door 0, falha=1.
  - FALHA is left only by reset; requests are still latched.
- Undefined: no counter or FALHA logic; falha tied 0; state code 4 unreachable.

Test Plan:
- Reset asserted mid-SUBINDO -> motor_sobe=0 asynchronously; all outputs 0, direcao=1, estado=0.
- At floor 0, pulse pedido=4'b0100 -> SUBINDO.
  - Floor hit andar_exato=1 -> keeps moving.
  - Floor hit andar_exato=2 -> PORTA: porta_aberta=1 for exactly 100 cycles, pedidos_pendentes=0, then PARADO.
- At floor 0, request 3; while moving, press floor 1 before hit at 1 -> stops at 1 (door 100 cycles), then resumes SUBINDO, stops at 3.
- At floor 2, direcao=1, pending {0,3} -> goes up to 3 first, then DESCENDO to 0, direcao=0.
- In PARADO at floor 1, press pedido[1] -> PORTA next cycle, no motor pulse. Re-press at cycle 50 -> door total 150 cycles.
- MOVE_TIMEOUT_EN: request 3 from floor 0, no floor hits for 2000 cycles -> FALHA, falha=1, motors 0; persists until reset.
